// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: captures the processor register write-back stream into a
// first-word-fall-through FIFO and drains it through a valid/ready read port.
//
// Optional build macro: WB_TRACE_DEDUP_EN drops a write-back whose data equals
// the most recently stored entry while capturing.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   arm                 start a capture (honoured only in IDLE)
//   wb_valid, wb_data   processor write-back strobe and data
//   rd_ready            consumer accepts the head entry
//   rd_valid, rd_data   head entry available / head entry data
//   count               occupied entries, 0..DEPTH
//   state               0 = IDLE, 1 = CAPTURE, 2 = FROZEN
//   drop_cnt            write-backs lost while FROZEN, saturating
module wb_trace_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  input  logic                    wb_valid,
  input  logic [DATA_W-1:0]       wb_data,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [DATA_W-1:0]       rd_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic [1:0]              state,
  output logic [15:0]             drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] Full       = (AW+1)'(DEPTH);
  localparam logic [AW:0] AlmostFull = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] One        = (AW+1)'(1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StFrozen  = 2'd2
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic [15:0]       drop_q;
  logic              push;
  logic              pop;
  logic              dup;

`ifdef WB_TRACE_DEDUP_EN
  logic [DATA_W-1:0] last_q;
  logic              last_vld_q;
  assign dup = last_vld_q && (wb_data == last_q);
`else
  assign dup = 1'b0;
`endif

  // Capture never sees a full FIFO (it freezes first); the guard keeps that explicit.
  assign push = (state_q == StCapture) && wb_valid && !dup && (count_q != Full);
  assign pop  = (count_q != '0) && rd_ready;

  assign rd_valid = (count_q != '0);
  assign rd_data  = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign state    = state_q;
  assign drop_cnt = drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
`ifdef WB_TRACE_DEDUP_EN
      last_q     <= '0;
      last_vld_q <= 1'b0;
`endif
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wb_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
`ifdef WB_TRACE_DEDUP_EN
        last_q     <= wb_data;
        last_vld_q <= 1'b1;
`endif
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end

      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      unique case (state_q)
        StIdle: begin
          if (arm) begin
            state_q <= StCapture;
            drop_q  <= '0;
`ifdef WB_TRACE_DEDUP_EN
            last_vld_q <= 1'b0;
`endif
          end
        end
        StCapture: begin
          // A concurrent pop keeps the FIFO below full.
          if (push && !pop && (count_q == AlmostFull)) begin
            state_q <= StFrozen;
          end
        end
        StFrozen: begin
          if (wb_valid && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 1'b1;
          end
          if (pop && (count_q == One)) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
module tb_wb_trace_buffer;

  localparam int unsigned DataW = 32;
  localparam int unsigned Depth = 16;
`ifdef WB_TRACE_DEDUP_EN
  localparam bit Dedup = 1'b1;
`else
  localparam bit Dedup = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             arm = 1'b0;
  logic             wb_valid = 1'b0;
  logic [DataW-1:0] wb_data = '0;
  logic             rd_ready = 1'b0;
  logic             rd_valid;
  logic [DataW-1:0] rd_data;
  logic [4:0]       count;
  logic [1:0]       state;
  logic [15:0]      drop_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model: FIFO contents as a queue, state as an integer.
  logic [31:0] m_fifo[$];
  logic [31:0] exp_q[$];
  int          m_state = 0;
  int          m_drop = 0;
  logic [31:0] m_last = '0;
  bit          m_last_vld = 1'b0;

  wb_trace_buffer #(
    .DATA_W (DataW),
    .DEPTH  (Depth)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .arm      (arm),
    .wb_valid (wb_valid),
    .wb_data  (wb_data),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .count    (count),
    .state    (state),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every handshake pops the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_pop", rd_data, 32'hDEAD_BEEF);
      end else begin
        chk("sb_data", rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic check_state();
    chk("state", 32'(state), 32'(m_state));
    chk("count", 32'(count), 32'(m_fifo.size()));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("rd_valid", 32'(rd_valid), 32'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) chk("rd_data", rd_data, m_fifo[0]);
  endtask

  // Called at posedge+1: drive inputs, advance the model across the next edge.
  task automatic step(input bit a, input bit v, input logic [31:0] d, input bit r);
    bit m_push = 1'b0;
    bit m_pop;
    arm = a; wb_valid = v; wb_data = d; rd_ready = r;
    m_pop = r && (m_fifo.size() > 0);
    if (m_state == 0 && a) begin
      m_drop = 0;
      m_last_vld = 1'b0;
    end
    if (m_state == 1 && v && !(Dedup && m_last_vld && d == m_last)) m_push = 1'b1;
    if (m_state == 2 && v && m_drop < 16'hFFFF) m_drop++;
    if (m_pop) void'(m_fifo.pop_front());
    if (m_push) begin
      m_fifo.push_back(d);
      exp_q.push_back(d);
      m_last = d;
      m_last_vld = 1'b1;
    end
    if (m_state == 0 && a) m_state = 1;
    else if (m_state == 1 && m_fifo.size() == Depth) m_state = 2;
    else if (m_state == 2 && m_fifo.size() == 0) m_state = 0;
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; arm = 1'b0; rd_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      wb_valid = i[0];
      wb_data = 32'h5A5A_0000 + i;
      @(posedge clk);
      #1;
    end
    m_fifo.delete();
    exp_q.delete();
    m_state = 0; m_drop = 0; m_last_vld = 1'b0;
    rst = 1'b0; wb_valid = 1'b0;
    check_state();
    chk("rst_rd_data", rd_data, 32'h0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset with write-back activity.
    do_reset(2);

    // Basic capture and drain.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 32'(i), 1'b0);
    drain(4);

    // Freeze and drop count.
    do_reset(1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 32'h100 + i, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'hBAD0 + i, 1'b0);
    chk("frozen_drops", 32'(drop_cnt), 32'd5);
    drain(17);
    chk("frozen_back_idle", 32'(state), 32'd0);

    // Wrap-around with concurrent traffic.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 32'(i), 1'b1);
    drain(2);

    // Reset mid-capture with 7 entries.
    do_reset(1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 32'h70 + i, 1'b0);
    chk("mid_count7", 32'(count), 32'd7);
    do_reset(1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'hAA, 1'b0);
    drain(2);

    // Dedup pattern; model decides whether repeats are stored.
    do_reset(1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h5, 1'b0);
    step(1'b0, 1'b1, 32'h5, 1'b0);
    step(1'b0, 1'b1, 32'h6, 1'b0);
    step(1'b0, 1'b1, 32'h5, 1'b0);
    chk("dedup_count", 32'(count), Dedup ? 32'd3 : 32'd4);
    drain(5);

    // Randomized traffic, alternating slow and fast consumer phases.
    for (int i = 0; i < 600; i++) begin
      bit r;
      if ((i / 100) % 2 == 0) r = ($urandom_range(0, 7) == 0);
      else r = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 149) == 0) do_reset(1);
      else step($urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0,
                32'($urandom_range(0, 3)), r);
    end
    drain(Depth + 2);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Capture buffer that sits directly downstream of the 32-bit processor and consumes its register write-back bus (`reg_write_data` plus a write-enable strobe). When armed, it records every retired write-back value into a first-word-fall-through FIFO. It freezes when full and drains to a bench or debug port through a valid/ready read handshake. It lets simulation and hardware bring-up check the exact sequence of register results without probing processor internals.

## Interface
- `DATA_W`, default 32: write-back data width; matches `reg_write_data`.
- `DEPTH`, default 16: FIFO entries; power of two, at least 2.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `arm`  in  1  single-cycle request to start a capture; honoured only in IDLE.
- `wb_valid`  in  1  processor register write-back strobe (RegWrite).
- `wb_data`  in  DATA_W  processor `reg_write_data`; sampled when `wb_valid` is high.
- `rd_ready`  in  1  consumer accepts the head entry.
- `rd_valid`  out  1  head entry available; equals `count != 0`.
- `rd_data`  out  DATA_W  head entry; driven directly from storage, so it is valid whenever `rd_valid` is high.
- `count`  out  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.
- `state`  out  2  current state: 0 = IDLE, 1 = CAPTURE, 2 = FROZEN.
- `drop_cnt`  out  16  write-backs lost while FROZEN; saturates at 16'hFFFF.

## Operation
- **Reset** (`rst` = 1 at an edge):
  - state goes to IDLE.
  - Write and read pointers, `count` and `drop_cnt` go to 0.
  - `rd_valid` is 0 and `rd_data` is 0 (storage is cleared).
  - Reset overrides every other input, including in the middle of a capture or drain.
- **IDLE:**
  - `wb_valid` is ignored and not counted as a drop.
  - `arm` = 1 moves to CAPTURE and clears `drop_cnt`.
  - Remaining entries can still be popped.
- **CAPTURE:**
  - Each `wb_valid` writes `wb_data` at the write pointer.
  - When `count` reaches DEPTH, the state moves to FROZEN on the same edge that writes the last entry.
  - `arm` is ignored.
- **FROZEN:**
  - No writes are accepted; each `wb_valid` increments `drop_cnt`, saturating at 16'hFFFF.
  - When a pop empties the FIFO (`count` goes to 0), the state returns to IDLE on that edge.
  - `arm` is ignored.
- **Pop:** a pop happens when `rd_valid && rd_ready`; the read pointer advances on that edge.
- **Pointers:** both are modulo DEPTH and wrap from DEPTH-1 to 0.
- **Simultaneous write and pop** in CAPTURE: `count` is unchanged.
  - If `count` = DEPTH-1, the state stays in CAPTURE because the FIFO does not fill.
- **Pop with no write:** in IDLE or CAPTURE, `count` decrements.
- **No overflow or underflow:** the FIFO is never written while full, and `count` never wraps.

## Timing
- **Write to read latency:** 1 cycle. A value written at edge k makes `rd_valid` = 1 and `rd_data` = that value in the cycle after edge k.
- **Pop:** the next entry appears on `rd_data` in the cycle after the popping edge.
- **Throughput:** 1 write per cycle and 1 pop per cycle, sustained concurrently.
- **Arm latency:** `arm` high at edge k puts `state` = 1 after edge k. A `wb_valid` at edge k is not captured; capture starts at edge k+1.
- **Registered outputs:** `state`, `count` and `drop_cnt` are registered.

## Configuration
- **`WB_TRACE_DEDUP_EN` defined:**
  - The block keeps a `last` register plus a `last_vld` flag.
  - In CAPTURE, a write-back with `wb_data == last` while `last_vld` is set is discarded. It is neither stored nor counted.
  - `last` and `last_vld` update on every stored entry.
  - `last_vld` is cleared by `rst` and by an accepted `arm`.
  - This compresses the trace when repeated writes produce the same value.
- **`WB_TRACE_DEDUP_EN` not defined:** every `wb_valid` in CAPTURE is stored, and the dedup registers are not built.

## Test plan
- **Reset values:** hold `rst` for 2 cycles with `wb_valid` toggling. Required: `state` = 0, `count` = 0, `rd_valid` = 0, `drop_cnt` = 0, and nothing captured.
- **Basic capture and drain:** arm, send writes 0x1, 0x2, 0x3, then hold `rd_ready` = 1. Required: `rd_data` reads 0x1, 0x2, 0x3 in order, each appearing 1 cycle after its write; `count` ends at 0.
- **Freeze and drop count:** arm, send 16 writes 0x100..0x10F, then 5 more write-backs. Required: `state` = 2 after the 16th write, `count` = 16, `drop_cnt` = 5. A full drain returns `state` = 0 and reads 0x100..0x10F.
- **Wrap-around with concurrent traffic:** arm, then run 40 consecutive cycles with `wb_valid` = 1 and `rd_ready` = 1, data incrementing from 0. Required: output sequence 0..39 with no gaps, `count` never above 1, `state` stays 1.
- **Reset mid-operation:** reset while `count` = 7 in CAPTURE. Required: next cycle `count` = 0, `rd_valid` = 0, `state` = 0. A following arm plus write 0xAA reads back 0xAA.
- **Dedup (with `WB_TRACE_DEDUP_EN` defined):** arm, send 0x5, 0x5, 0x6, 0x5. Required: stored sequence 0x5, 0x6, 0x5 and `count` = 3. With the macro not defined, `count` = 4.
